// File: rtl/cs_seq_pkg.sv
// Shared types and helpers for the chip-select power-up / transfer sequencer.
package cs_seq_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        CS_RESET  = 3'd0,
        CS_ENABLE = 3'd1,
        CS_SETTLE = 3'd2,
        CS_WRITE  = 3'd3,
        CS_READY  = 3'd4,
        CS_FAULT  = 3'd5
    } cs_state_t;

    // States in which the interface clock divider is allowed to run.
    function automatic logic cs_running(input cs_state_t s);
        return (s == CS_ENABLE) || (s == CS_SETTLE) || (s == CS_READY) || (s == CS_WRITE);
    endfunction

    function automatic int cs_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cs_clk_div.sv
// Divided 50%-duty interface clock with a one-cycle pulse on each rising phase.
module cs_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic clk_cs,
    output logic cs_tick
);

    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [DW-1:0] HALF_LAST = DW'(HALF - 1);

    logic [DW-1:0] div_q;
    logic          clk_cs_q;
    logic          cs_tick_q;

    // Stopping the divider also drops clk_cs on the same edge, so no runt high phase.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_q     <= '0;
            clk_cs_q  <= 1'b0;
            cs_tick_q <= 1'b0;
        end else if (div_q == HALF_LAST) begin
            div_q     <= '0;
            clk_cs_q  <= ~clk_cs_q;
            cs_tick_q <= ~clk_cs_q;
        end else begin
            div_q     <= div_q + 1'b1;
            cs_tick_q <= 1'b0;
        end
    end

    assign clk_cs  = clk_cs_q;
    assign cs_tick = cs_tick_q;

endmodule

// File: rtl/cs_sequencer.sv
// Power-up, clock-start and write-supervision sequencer for a chip-select peripheral.
module cs_sequencer
    import cs_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 5,
    parameter int SETTLE_CYCLES   = 3,
    parameter int CLK_DIV         = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               restart,
    input  logic               we_en,
    input  logic               flag_cs,
    output logic [STATE_W-1:0] state_o,
    output logic               rst_cs,
    output logic               clk_cs,
    output logic               cs_tick,
    output logic               busy,
    output logic               fault
);

    localparam int MAX_CYC = cs_max3(RST_HOLD_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TO_EN       = (TIMEOUT_CYCLES > 0);

    cs_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rst_cs_q, busy_q, fault_q;
    logic             div_run;

    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = CS_RESET;
        end else begin
            case (state_q)
                CS_RESET:  if (cnt_q == HOLD_LAST) state_d = CS_ENABLE;
                CS_ENABLE: state_d = CS_SETTLE;
                CS_SETTLE: if (cnt_q == SETTLE_LAST) state_d = CS_READY;
                CS_READY:  if (we_en) state_d = CS_WRITE;
                CS_WRITE: begin
                    // Completion is checked first so a falling flag beats a same-cycle timeout.
                    if (!flag_cs)
                        state_d = CS_SETTLE;
                    else if (TO_EN && (cnt_q == TO_LAST))
                        state_d = CS_FAULT;
                end
                CS_FAULT:  state_d = CS_FAULT;
                default:   state_d = CS_RESET;
            endcase
        end
    end

    // Shared cycle counter: cleared on any state change (or restart), saturates otherwise.
    always_comb begin
        cnt_d = cnt_q;
        if (restart || (state_d != state_q))
            cnt_d = '0;
        else if (cnt_q != '1)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= CS_RESET;
            cnt_q    <= '0;
            rst_cs_q <= 1'b1;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rst_cs_q <= !cs_running(state_d);
            busy_q   <= (state_d == CS_WRITE);
            fault_q  <= (state_d == CS_FAULT);
        end
    end

    // The divider only counts once ENABLE is the current state, and stops on the
    // very edge that leaves the running group.
    assign div_run = cs_running(state_q) && cs_running(state_d);

    cs_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk     (clk),
        .rst     (rst),
        .run     (div_run),
        .clk_cs  (clk_cs),
        .cs_tick (cs_tick)
    );

    assign state_o = state_q;
    assign rst_cs  = rst_cs_q;
    assign busy    = busy_q;
    assign fault   = fault_q;

endmodule

// File: tb/tb_cs_sequencer.sv
// Self-checking bench: two sequencer configurations against a timeline-based reference model.
module tb_cs_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic restart = 1'b0;
    logic we_en = 1'b0;
    logic flag_cs = 1'b0;

    always #5 clk = ~clk;

    logic [2:0] st0, st1;
    logic rc0, rc1, ck0, ck1, tk0, tk1, bz0, bz1, ft0, ft1;

    cs_sequencer dut0 (
        .clk(clk), .rst(rst), .restart(restart), .we_en(we_en), .flag_cs(flag_cs),
        .state_o(st0), .rst_cs(rc0), .clk_cs(ck0), .cs_tick(tk0), .busy(bz0), .fault(ft0)
    );

    cs_sequencer #(
        .RST_HOLD_CYCLES(1), .SETTLE_CYCLES(3), .CLK_DIV(2), .TIMEOUT_CYCLES(0)
    ) dut1 (
        .clk(clk), .rst(rst), .restart(restart), .we_en(we_en), .flag_cs(flag_cs),
        .state_o(st1), .rst_cs(rc1), .clk_cs(ck1), .cs_tick(tk1), .busy(bz1), .fault(ft1)
    );

    // Reference model parameters per instance
    int p_hold   [2] = '{5, 1};
    int p_settle [2] = '{3, 3};
    int p_half   [2] = '{2, 1};
    int p_to     [2] = '{16, 0};

    localparam int S_RESET = 0, S_ENABLE = 1, S_SETTLE = 2, S_WRITE = 3, S_READY = 4, S_FAULT = 5;

    int m_st  [2] = '{0, 0};
    int m_age [2] = '{0, 0};
    int m_ds  [2] = '{0, 0};
    bit m_valid = 1'b0;
    int cyc = 0;
    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_running(input int s);
        return (s >= S_ENABLE) && (s <= S_READY);
    endfunction

    task automatic check_dut(input int d, input logic [2:0] st, input logic rc, input logic ck,
                             input logic tk, input logic bz, input logic ft);
        int s;
        int e_ck, e_tk;
        s = m_st[d];
        e_ck = 0;
        e_tk = 0;
        if (m_running(s)) begin
            e_ck = ((cyc - m_ds[d]) / p_half[d]) % 2;
            e_tk = (((cyc - m_ds[d]) % (2 * p_half[d])) == p_half[d]) ? 1 : 0;
        end
        chk($sformatf("d%0d.state", d), 32'(st), s);
        chk($sformatf("d%0d.rst_cs", d), 32'(rc), (s == S_RESET || s == S_FAULT) ? 1 : 0);
        chk($sformatf("d%0d.clk_cs", d), 32'(ck), e_ck);
        chk($sformatf("d%0d.cs_tick", d), 32'(tk), e_tk);
        chk($sformatf("d%0d.busy", d), 32'(bz), (s == S_WRITE) ? 1 : 0);
        chk($sformatf("d%0d.fault", d), 32'(ft), (s == S_FAULT) ? 1 : 0);
    endtask

    task automatic model_step(input int d, input bit r, input bit rs, input bit we, input bit fl);
        int cur, nx;
        cur = m_st[d];
        nx = cur;
        if (r || rs) begin
            nx = S_RESET;
        end else begin
            case (cur)
                S_RESET:  if (m_age[d] + 1 >= p_hold[d]) nx = S_ENABLE;
                S_ENABLE: nx = S_SETTLE;
                S_SETTLE: if (m_age[d] + 1 >= p_settle[d]) nx = S_READY;
                S_READY:  if (we) nx = S_WRITE;
                S_WRITE: begin
                    if (!fl) nx = S_SETTLE;
                    else if (p_to[d] > 0 && m_age[d] + 1 >= p_to[d]) nx = S_FAULT;
                end
                default:  nx = cur;
            endcase
        end
        if (d == 0 && cur == S_WRITE && nx != S_WRITE)
            $display("xfer cyc=%0d beats=%0d end=%s", cyc, m_age[d] + 1,
                     (nx == S_SETTLE) ? "done" : (nx == S_FAULT) ? "timeout" : "abort");
        if (m_running(nx) && !m_running(cur))
            m_ds[d] = cyc + 1;
        if (r || rs || nx != cur)
            m_age[d] = 0;
        else
            m_age[d] = m_age[d] + 1;
        m_st[d] = nx;
    endtask

    // One clock cycle: check the state produced by the last edge, then drive this cycle's inputs.
    task automatic cycle(input bit r, input bit rs, input bit we, input bit fl);
        @(negedge clk);
        if (m_valid) begin
            check_dut(0, st0, rc0, ck0, tk0, bz0, ft0);
            check_dut(1, st1, rc1, ck1, tk1, bz1, ft1);
        end
        rst = r;
        restart = rs;
        we_en = we;
        flag_cs = fl;
        model_step(0, r, rs, we, fl);
        model_step(1, r, rs, we, fl);
        if (r) m_valid = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    task automatic write_flag(input int n_high);
        cycle(0, 0, 1, 1);
        for (int i = 0; i < n_high; i++) cycle(0, 0, 0, 1);
    endtask

    initial begin
        // Reset release and power-up sequence
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        idle(15);

        // Normal transfer: 6 busy-flag cycles then completion
        write_flag(6);
        idle(6);

        // Timeout into FAULT, then soft restart
        write_flag(20);
        cycle(0, 1, 0, 0);
        idle(15);

        // Flag falls on the same cycle the timeout would fire
        write_flag(15);
        idle(6);

        // Mid-transfer reset, then reset together with restart
        write_flag(3);
        cycle(1, 0, 0, 1);
        idle(15);
        write_flag(3);
        cycle(1, 1, 0, 1);
        idle(15);

        // Long busy flag: instance 1 has the timeout disabled
        write_flag(1000);
        idle(4);
        cycle(0, 1, 0, 0);
        idle(15);

        // Restart during the reset hold restarts the count
        cycle(0, 1, 0, 0);
        idle(2);
        cycle(0, 1, 0, 0);
        idle(12);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            bit r, rs, we, fl;
            r  = ($urandom_range(0, 299) == 0);
            rs = ($urandom_range(0, 149) == 0);
            we = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 9) != 0);
            cycle(r, rs, we, fl);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
